sensor_seq_gen: RTL

- Stimulus-side counterpart of the two-sensor access controller: drives the sensor pulses C1, C2 and the interrupt I in a programmed order and spacing.
- Then waits for the controller's 2-bit Ca response and checks it against an expected code, with a timeout.
- Sits in the top-level wrapper as an on-chip self-test sequencer. Its outputs are muxed onto the controller's C1/C2/I inputs, and its `ca` input taps the controller's Ca.

---
 rtl/sensor_seq_pkg.sv | 23 ++
 rtl/seq_down_timer.sv | 39 +++
 rtl/sensor_seq_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_seq_pkg.sv
// sensor_seq_pkg: shared types and constants for the sensor stimulus sequencer.
//   seq_state_e    : sequencer state, 3-bit binary encoding
//   ORDER_*        : meaning of the 'order' input
//   CA_W           : width of the controller response code
package sensor_seq_pkg;

  localparam int unsigned CA_W = 2;

  localparam logic ORDER_C1_FIRST = 1'b0;
  localparam logic ORDER_C2_FIRST = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    GAP1   = 3'd2,
    INTR   = 3'd3,
    GAP2   = 3'd4,
    SECOND = 3'd5,
    WAIT   = 3'd6,
    DONE   = 3'd7
  } seq_state_e;

endpackage

// File: rtl/seq_down_timer.sv
// seq_down_timer: loadable down-counter with a zero flag. Stops at zero.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when nonzero
//   zero       : count is zero
module seq_down_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sensor_seq_gen.sv
// sensor_seq_gen: on-chip self-test sequencer for the two-sensor access
// controller. Drives C1/C2/I in a programmed order and spacing, then waits
// for the controller's Ca response and compares it with an expected code.
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a sequence (accepted only in IDLE)
//   order          : 0 = C1 then C2, 1 = C2 then C1 (latched at start)
//   gap            : idle cycles after first pulse and after I (latched)
//   exp_ca         : expected response (latched)
//   ca             : controller response, sampled each WAIT cycle
//   c1_o/c2_o/i_o  : sensor and interrupt drives
//   busy           : high outside IDLE
//   done, pass     : one-cycle end pulse; pass valid while done=1
//   ca_last        : last ca sampled in WAIT
// Build option: define SENSOR_SEQ_HOLD_EN to hold each sensor drive high
// from its first assertion until the end of DONE (i_o stays a pulse).
module sensor_seq_gen
  import sensor_seq_pkg::*;
#(
  parameter int unsigned GAP_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             order,
  input  logic [GAP_W-1:0] gap,
  input  logic [CA_W-1:0]  exp_ca,
  input  logic [CA_W-1:0]  ca,
  output logic             c1_o,
  output logic             c2_o,
  output logic             i_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CA_W-1:0]  ca_last
);

  seq_state_e       state_q, state_d;
  logic             order_q, order_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CA_W-1:0]  exp_q, exp_d;
  logic [CA_W-1:0]  ca_last_q, ca_last_d;
  logic             pass_q, pass_d;

  logic gap_load, gap_en, gap_zero;
  logic to_load, to_en, to_zero;
  logic first_on, second_on;

  seq_down_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  seq_down_timer #(.W(8)) u_timeout_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (8'(TIMEOUT - 1)),
    .en       (to_en),
    .zero     (to_zero)
  );

  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    gap_d     = gap_q;
    exp_d     = exp_q;
    ca_last_d = ca_last_q;
    pass_d    = pass_q;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    to_load   = 1'b0;
    to_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          order_d = order;
          gap_d   = gap;
          exp_d   = exp_ca;
          pass_d  = 1'b0;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (gap_q == '0) begin
          state_d = INTR;
        end else begin
          gap_load = 1'b1;
          state_d  = GAP1;
        end
      end
      GAP1: begin
        if (gap_zero) begin
          state_d = INTR;
        end else begin
          gap_en = 1'b1;
        end
      end
      INTR: begin
        if (gap_q == '0) begin
          state_d = SECOND;
        end else begin
          gap_load = 1'b1;
          state_d  = GAP2;
        end
      end
      GAP2: begin
        if (gap_zero) begin
          state_d = SECOND;
        end else begin
          gap_en = 1'b1;
        end
      end
      SECOND: begin
        to_load = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        ca_last_d = ca;
        // A match on the last allowed cycle still counts as a pass.
        if (ca == exp_q) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (to_zero) begin
          pass_d  = 1'b0;
          state_d = DONE;
        end else begin
          to_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      order_q   <= 1'b0;
      gap_q     <= '0;
      exp_q     <= '0;
      ca_last_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      gap_q     <= gap_d;
      exp_q     <= exp_d;
      ca_last_q <= ca_last_d;
      pass_q    <= pass_d;
    end
  end

  // Drives decode from registered state only; in level mode the held
  // sensors are derived from the state position, so reset clears them.
`ifdef SENSOR_SEQ_HOLD_EN
  assign first_on  = (state_q != IDLE);
  assign second_on = (state_q == SECOND) || (state_q == WAIT) || (state_q == DONE);
`else
  assign first_on  = (state_q == FIRST);
  assign second_on = (state_q == SECOND);
`endif

  assign c1_o    = (order_q == ORDER_C1_FIRST) ? first_on : second_on;
  assign c2_o    = (order_q == ORDER_C1_FIRST) ? second_on : first_on;
  assign i_o     = (state_q == INTR);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign pass    = (state_q == DONE) && pass_q;
  assign ca_last = ca_last_q;

endmodule
